// File: rtl/pc_sequencer_if.sv
// Handshake/bus bundle between the PC sequencer and its neighbours
// (main control, hazard unit, branch logic, PC register).
interface pc_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              halt_req;
  logic              resume;
  logic              hazard_stall;
  logic              imem_ready;
  logic              jmp_valid;
  logic [ADDR_W-1:0] jmp_target;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] pc_current;
  logic [ADDR_W-1:0] next_address;
  logic              pc_halt;
  logic              pc_stall;
  logic              flush_if;
  logic              flush_id;
  logic              align_err;
  logic [2:0]        seq_state;

  modport master (
    output halt_req, resume, hazard_stall, imem_ready,
    output jmp_valid, jmp_target, br_taken, br_target, pc_current,
    input  next_address, pc_halt, pc_stall, flush_if, flush_id,
    input  align_err, seq_state
  );

  modport slave (
    input  halt_req, resume, hazard_stall, imem_ready,
    input  jmp_valid, jmp_target, br_taken, br_target, pc_current,
    output next_address, pc_halt, pc_stall, flush_if, flush_id,
    output align_err, seq_state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch address each cycle and drives
// the PC register halt/stall controls plus IF/ID flush pulses after redirects.
module pc_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter int                PC_INC       = 2,
  parameter int                FLUSH_CYCLES = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}}
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_HALTED   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(PC_INC);
  localparam logic [2:0]        CNT_LOAD = 3'(FLUSH_CYCLES - 1);
  // With a single bubble the redirect cycle itself is the whole flush.
  localparam state_t            REDIR_ST = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  state_t            state_r, state_nxt;
  logic [2:0]        cnt_r, cnt_nxt;
  logic              align_r, align_nxt;
  logic [ADDR_W-1:0] next_address_s;
  logic              halt_s, stall_s, flush_s;
  logic              redirect_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] seq_addr_s;

  assign redirect_s = bus.jmp_valid | bus.br_taken;
  assign target_s   = bus.jmp_valid ? bus.jmp_target : bus.br_target;
  assign seq_addr_s = bus.pc_current + INC_V;

  // State, bubble counter and alignment flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_BOOT;
      cnt_r   <= 3'd0;
      align_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      align_r <= align_nxt;
    end
  end

  // Next-state and combinational PC-register controls.
  always_comb begin
    state_nxt      = state_r;
    cnt_nxt        = cnt_r;
    align_nxt      = 1'b0;
    next_address_s = bus.pc_current;
    halt_s         = 1'b0;
    stall_s        = 1'b0;
    flush_s        = 1'b0;
    case (state_r)
      ST_BOOT: begin
        next_address_s = RESET_VECTOR;
        stall_s        = 1'b1;
        state_nxt      = ST_RUN;
      end
      ST_HALTED: begin
        halt_s = 1'b1;
        if (bus.resume && !bus.halt_req) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_HALTED;
        end
      end
      // MEM_WAIT shares RUN's rules: a ready memory simply falls through them.
      ST_RUN, ST_MEM_WAIT, ST_FLUSH: begin
        if (bus.halt_req) begin
          halt_s    = 1'b1;
          state_nxt = ST_HALTED;
        end else if (redirect_s) begin
          next_address_s = {target_s[ADDR_W-1:1], 1'b0};
          align_nxt      = target_s[0];
          flush_s        = 1'b1;
          cnt_nxt        = CNT_LOAD;
          state_nxt      = REDIR_ST;
        end else if (state_r == ST_FLUSH) begin
          flush_s        = 1'b1;
          next_address_s = seq_addr_s;
          cnt_nxt        = cnt_r - 3'd1;
          if (cnt_r <= 3'd1) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_FLUSH;
          end
        end else if (!bus.imem_ready) begin
          stall_s   = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end else if (bus.hazard_stall) begin
          stall_s   = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          next_address_s = seq_addr_s;
          state_nxt      = ST_RUN;
        end
      end
      default: begin
        next_address_s = RESET_VECTOR;
        stall_s        = 1'b1;
        state_nxt      = ST_BOOT;
        cnt_nxt        = 3'd0;
      end
    endcase
  end

  assign bus.next_address = next_address_s;
  assign bus.pc_halt      = halt_s;
  assign bus.pc_stall     = stall_s;
  assign bus.flush_if     = flush_s;
  assign bus.flush_id     = flush_s;
  assign bus.align_err    = align_r;
  assign bus.seq_state    = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer against a behavioural PC model.
module tb_pc_sequencer;

  localparam int          FC = 2;
  localparam logic [15:0] RV = 16'h0000;
  localparam int M_BOOT = 0, M_RUN = 1, M_WAIT = 2, M_FLUSH = 3, M_HALT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(16)) bus ();

  pc_sequencer #(
    .ADDR_W(16), .PC_INC(2), .FLUSH_CYCLES(FC), .RESET_VECTOR(RV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: operating mode, remaining bubble cycles, PC register.
  int          mode;
  int          bubbles;
  logic [15:0] pc;
  logic        exp_align;
  logic [15:0] e_next;
  logic        e_halt, e_stall, e_flush, n_align;
  int          n_mode, n_bub;
  logic [15:0] obs_next;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = M_BOOT; bubbles = 0; pc = RV; exp_align = 1'b0;
  endtask

  task automatic model_eval();
    logic [15:0] tgt;
    e_next = pc; e_halt = 1'b0; e_stall = 1'b0; e_flush = 1'b0;
    n_mode = mode; n_bub = bubbles; n_align = 1'b0;
    if (mode == M_BOOT) begin
      e_next = RV; e_stall = 1'b1; n_mode = M_RUN;
    end else if (mode == M_HALT) begin
      e_halt = 1'b1;
      if (bus.resume && !bus.halt_req) n_mode = M_RUN;
    end else if (bus.halt_req) begin
      e_halt = 1'b1; n_mode = M_HALT;
    end else if (bus.jmp_valid || bus.br_taken) begin
      tgt = bus.jmp_valid ? bus.jmp_target : bus.br_target;
      e_next = tgt - (tgt % 16'd2);
      n_align = (tgt % 16'd2) != 16'd0;
      e_flush = 1'b1;
      n_bub = FC - 1;
      n_mode = (n_bub > 0) ? M_FLUSH : M_RUN;
    end else if (mode == M_FLUSH) begin
      e_flush = 1'b1; e_next = pc + 16'd2;
      n_bub = bubbles - 1;
      n_mode = (n_bub == 0) ? M_RUN : M_FLUSH;
    end else if (!bus.imem_ready) begin
      e_stall = 1'b1; n_mode = M_WAIT;
    end else if (bus.hazard_stall) begin
      e_stall = 1'b1; n_mode = M_RUN;
    end else begin
      e_next = pc + 16'd2; n_mode = M_RUN;
    end
  endtask

  task automatic step(input logic h, input logic rs, input logic hz, input logic im,
                      input logic jv, input logic [15:0] jt,
                      input logic bt, input logic [15:0] btg);
    @(negedge clk);
    bus.halt_req = h; bus.resume = rs; bus.hazard_stall = hz; bus.imem_ready = im;
    bus.jmp_valid = jv; bus.jmp_target = jt; bus.br_taken = bt; bus.br_target = btg;
    bus.pc_current = pc;
    #1;
    model_eval();
    obs_next = bus.next_address;
    check_val("next_address", {16'h0, bus.next_address}, {16'h0, e_next});
    check_val("pc_halt", {31'h0, bus.pc_halt}, {31'h0, e_halt});
    check_val("pc_stall", {31'h0, bus.pc_stall}, {31'h0, e_stall});
    check_val("flush_if", {31'h0, bus.flush_if}, {31'h0, e_flush});
    check_val("flush_id", {31'h0, bus.flush_id}, {31'h0, e_flush});
    check_val("align_err", {31'h0, bus.align_err}, {31'h0, exp_align});
    check_val("seq_state", {29'h0, bus.seq_state}, 32'(mode));
    @(posedge clk);
    #1;
    if (!e_halt && !e_stall) pc = e_next;
    mode = n_mode; bubbles = n_bub; exp_align = n_align;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_next"}, {16'h0, bus.next_address}, {16'h0, RV});
    check_val({tag, "_stall"}, {31'h0, bus.pc_stall}, 32'd1);
    check_val({tag, "_halt"}, {31'h0, bus.pc_halt}, 32'd0);
    check_val({tag, "_flush"}, {30'h0, bus.flush_if, bus.flush_id}, 32'd0);
    check_val({tag, "_align"}, {31'h0, bus.align_err}, 32'd0);
    check_val({tag, "_state"}, {29'h0, bus.seq_state}, 32'd0);
  endtask

  initial begin
    bus.halt_req = 1'b0; bus.resume = 1'b0; bus.hazard_stall = 1'b0;
    bus.imem_ready = 1'b1; bus.jmp_valid = 1'b0; bus.jmp_target = 16'h0;
    bus.br_taken = 1'b0; bus.br_target = 16'h0; bus.pc_current = 16'h1234;
    model_reset();
    #12;
    check_reset_values("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Boot: one stalled cycle, then 0000, 0002, 0004.
    idle(); idle(); idle();

    // Odd branch target from pc 0x0010.
    pc = 16'h0010;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0041);
    check_val("tp_branch_target", {16'h0, obs_next}, 32'h0040);
    idle();
    idle();
    check_val("tp_after_flush", {16'h0, obs_next}, 32'h0044);

    // Jump beats branch in the same cycle.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b1, 16'h0200);
    check_val("tp_jump_wins", {16'h0, obs_next}, 32'h0100);
    idle(); idle();

    // Instruction memory wait with a hazard pulse inside the window.
    pc = 16'h0020;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    idle();
    check_val("tp_after_wait", {16'h0, obs_next}, 32'h0022);

    // Halt during FLUSH, resume ignored while halt_req is high.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0030, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0500);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0700, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    idle();
    check_val("tp_resume_fetch", {16'h0, obs_next}, 32'h0032);

    // Address wrap.
    pc = 16'hFFFE;
    idle();
    check_val("tp_wrap", {16'h0, obs_next}, 32'h0000);

    // Asynchronous reset in the middle of FLUSH, with align_err pending.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0333);
    @(negedge clk);
    bus.br_taken = 1'b0; bus.pc_current = pc;
    #2 rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    idle(); idle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] jt, btg;
      jt  = 16'($urandom);
      btg = 16'($urandom);
      step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 7, jt, $urandom_range(0, 99) < 10, btg);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block that sequences the program counter register each cycle.
- Computes the next fetch address and drives the PC register's next-address, halt and stall controls.
- Arbitrates between sequential fetch, jump and branch redirects, hazard stalls, instruction-memory wait and system halt.
- Raises flush pulses for the IF/ID pipeline registers after a taken redirect; sits between main control, hazard unit, branch logic and the PC register.

Parameters:
- ADDR_W, 16, address width.
- PC_INC, 2, byte increment for sequential fetch.
- FLUSH_CYCLES, 2, bubble cycles after a taken redirect (1..7).
- RESET_VECTOR, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- halt_req  in  1  main control halt request, level.
- resume  in  1  single-cycle pulse that leaves HALTED.
- hazard_stall  in  1  hazard-unit stall, level.
- imem_ready  in  1  instruction memory has data for pc_current.
- jmp_valid  in  1  unconditional jump resolved this cycle.
- jmp_target  in  ADDR_W  jump destination.
- br_taken  in  1  conditional branch resolved taken this cycle.
- br_target  in  ADDR_W  branch destination.
- pc_current  in  ADDR_W  current PC register output.
- next_address  out  ADDR_W  next-PC value to the PC register.
- pc_halt  out  1  drives PC register halt input.
- pc_stall  out  1  drives PC register stall input.
- flush_if  out  1  squash IF/ID register contents.
- flush_id  out  1  squash ID/EX register contents.
- align_err  out  1  one-cycle pulse: odd redirect target was received.
- seq_state  out  3  encoded FSM state, for debug.

Behaviour:
- Reset (rst=0, asynchronous) forces all of the following, held until the first clk edge after rst deasserts:
  - state=BOOT, next_address=RESET_VECTOR, pc_stall=1;
  - pc_halt=0, flush_if=0, flush_id=0, align_err=0;
  - bubble counter=0.
- States and encodings: BOOT=0, RUN=1, MEM_WAIT=2, FLUSH=3, HALTED=4.
- BOOT: lasts 1 cycle with pc_stall=1, then goes to RUN.
- RUN priority (highest first): halt_req > jmp_valid > br_taken > !imem_ready > hazard_stall > sequential.
  - halt_req: pc_halt=1, go to HALTED; any redirect in the same cycle is discarded.
  - jmp_valid, or br_taken: next_address = target with bit0 forced to 0; align_err pulses if target bit0 was 1; flush_if=flush_id=1 combinationally this cycle; load counter with FLUSH_CYCLES-1; go to FLUSH (or stay in RUN if FLUSH_CYCLES=1). Jump wins over branch if both are asserted.
  - !imem_ready: pc_stall=1, next_address=pc_current, go to MEM_WAIT.
  - hazard_stall: pc_stall=1 for that cycle only, stay in RUN.
  - sequential: next_address = pc_current + PC_INC, modulo 2^ADDR_W (16'hFFFE wraps to 16'h0000, no flag).
- MEM_WAIT:
  - pc_stall=1 while imem_ready=0.
  - On imem_ready=1, return to RUN and apply RUN rules in that same cycle.
  - halt_req is still honoured immediately.
  - Redirects arriving here are applied as in RUN, and the stall is dropped for that cycle.
- FLUSH:
  - flush_if=1 and flush_id=1 each cycle; PC advances sequentially from the target.
  - Counter decrements each cycle; at 0, go to RUN.
  - A new redirect reloads the counter and updates next_address (latest redirect wins).
  - halt_req aborts to HALTED with flushes deasserted.
- HALTED:
  - pc_halt=1, pc_stall=0, flushes 0; redirects and stalls are ignored.
  - resume=1 with halt_req=0: go to RUN next cycle.
  - resume with halt_req still high: ignored.
- Registered vs combinational outputs:
  - pc_halt, pc_stall, flushes and next_address are combinational from state plus inputs, so the PC register responds at the same edge.
  - align_err and seq_state are registered.
- Reset during any state: immediate return to BOOT values; no residual flush.
- All arithmetic is unsigned and ADDR_W wide.

Test Plan:
- Reset then release, imem_ready=1 -> BOOT stall for 1 cycle; next_address sequence 0000, 0002, 0004; seq_state 0->1.
- In RUN at pc 0x0010, assert br_taken with br_target=0x0041 -> next_address=0x0040, align_err pulse; flush_if/flush_id high for 2 cycles; back in RUN at 0x0044.
- Same cycle: jmp_valid (target 0x0100) and br_taken (target 0x0200), FLUSH_CYCLES=2 -> next_address=0x0100, branch ignored.
- imem_ready low 3 cycles at pc 0x0020, hazard_stall pulsed inside that window -> pc_stall high for exactly 3 cycles, pc held at 0x0020, then 0x0022.
- halt_req during FLUSH, pc 0x0030 -> pc_halt=1, flushes drop; resume while halt_req=1 ignored; after halt_req=0, resume -> RUN, fetch continues at 0x0032.
- pc_current=0xFFFE, sequential -> next_address=0x0000; async rst pulse mid-FLUSH -> outputs reset immediately without waiting for clk.
